// File: rtl/int_alu.sv
// rtl/int_alu.sv - integer ALU peripheral: add/sub/mul in one edge, restoring divide over WIDTH edges.
module int_alu #(
  parameter int          WIDTH = 32,
  parameter logic [3:0]  BASE  = 4'h5
) (
  input  logic         clk,
  input  logic         Reset,
  inout  wire  [255:0] bus,
  input  logic [15:0]  addr,
  input  logic         nRead,
  input  logic         nWrite,
  output logic         busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, DIV} state_t;

  state_t             state;
  logic [WIDTH-1:0]   a, b, result;
  logic [WIDTH-1:0]   dvd, dvs, rem;
  logic [CW-1:0]      cnt;
  logic               div0, badop;

  logic               sel, wr, rd;
  logic [11:0]        slot;
  logic [WIDTH-1:0]   wdata;
  logic [3:0]         cmd;
  logic [255:0]       rd_data;

  assign sel   = (addr[15:12] == BASE);
  assign wr    = sel & ~nWrite & nRead;
  assign rd    = sel & ~nRead & nWrite;
  assign slot  = addr[11:0];
  assign wdata = bus[WIDTH-1:0];
  assign cmd   = bus[3:0];

  always_comb begin
    rd_data = '0;
    case (slot)
      12'd2:   rd_data[WIDTH-1:0] = result;
      12'd4:   rd_data[2:0]       = {badop, div0, busy};
      default: rd_data = '0;
    endcase
  end

  assign bus = rd ? rd_data : {256{1'bz}};

  // One restoring step: shift remainder:dividend left, trial-subtract the divisor.
  logic [WIDTH:0]     rem_sh, trial;
  logic               q_bit;
  logic [WIDTH-1:0]   step_rem, step_dvd;

  assign rem_sh   = {rem, dvd[WIDTH-1]};
  assign trial    = rem_sh - {1'b0, dvs};
  assign q_bit    = ~trial[WIDTH];
  assign step_rem = q_bit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign step_dvd = {dvd[WIDTH-2:0], q_bit};

  always_ff @(negedge clk) begin
    if (Reset) begin
      a      <= '0;
      b      <= '0;
      result <= '0;
      div0   <= 1'b0;
      badop  <= 1'b0;
      dvd    <= '0;
      dvs    <= '0;
      rem    <= '0;
      cnt    <= '0;
      state  <= IDLE;
      busy   <= 1'b0;
    end else begin
      // Operand writes are accepted in any state; the divider works on its own copies.
      if (wr && slot == 12'd0) a <= wdata;
      if (wr && slot == 12'd1) b <= wdata;

      case (state)
        IDLE: begin
          if (wr && slot == 12'd3) begin
            div0  <= 1'b0;
            badop <= 1'b0;
            case (cmd)
              4'd0: result <= a + b;
              4'd1: result <= a - b;
              4'd2: result <= a * b;
              4'd3: begin
                if (b == '0) begin
                  result <= '1;
                  div0   <= 1'b1;
                end else begin
                  dvd   <= a;
                  dvs   <= b;
                  rem   <= '0;
                  cnt   <= CW'(WIDTH);
                  state <= DIV;
                  busy  <= 1'b1;
                end
              end
              default: begin
                result <= '0;
                badop  <= 1'b1;
              end
            endcase
          end
        end
        DIV: begin
          rem <= step_rem;
          dvd <= step_dvd;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            result <= step_dvd;
            state  <= IDLE;
            busy   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
